// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_if : data-memory request/response bus                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dmem_responder_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic        mem_req_valid_i;
  logic        mem_req_ready_o;
  logic        mem_rsp_valid_o;
  logic        mem_rsp_ready_i;
  logic [31:0] mem_rdata_o;

  modport master (
    output mem_addr_i, mem_wdata_i, mem_we_i, mem_sel_i, mem_req_valid_i, mem_rsp_ready_i,
    input  mem_req_ready_o, mem_rsp_valid_o, mem_rdata_o
  );

  modport slave (
    input  mem_addr_i, mem_wdata_i, mem_we_i, mem_sel_i, mem_req_valid_i, mem_rsp_ready_i,
    output mem_req_ready_o, mem_rsp_valid_o, mem_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : single-outstanding word RAM with programmable       |
// | response latency and byte-masked stores.          Rev 1.0            |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned c_aw     = $clog2(DEPTH);
  localparam logic [2:0]  c_lat_m1 = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [31:0] r_cap;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic [c_aw-1:0] w_idx;
  logic            w_req_ready;
  logic            w_accept;
  logic [31:0]     w_acc_data;

  assign w_idx       = bus.mem_addr_i[c_aw+1:2];
  assign w_req_ready = (r_state == IDLE) | ((r_state == RSP) & bus.mem_rsp_ready_i);
  assign w_accept    = bus.mem_req_valid_i & w_req_ready;
  // Load data is the pre-edge word; stores answer with zero.
  assign w_acc_data  = bus.mem_we_i ? 32'h0 : r_mem[w_idx];

  assign bus.mem_req_ready_o = w_req_ready;
  assign bus.mem_rsp_valid_o = (r_state == RSP);
  assign bus.mem_rdata_o     = r_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: w_state_nxt = IDLE;
      WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_nxt = RSP;
      end
      RSP: begin
        if (bus.mem_rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      w_cnt_nxt   = c_lat_m1;
      w_state_nxt = (LATENCY == 1) ? RSP : WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_cap   <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_cap <= w_acc_data;
      // Output register only carries data while a response is presented.
      r_rdata <= (w_state_nxt == RSP) ? (w_accept ? w_acc_data : r_cap) : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus.mem_we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.mem_sel_i[n]) r_mem[w_idx][8*n +: 8] <= bus.mem_wdata_i[8*n +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target-side end of the execution unit's data-memory request/response interface: a single-outstanding, word-organised data RAM responder.
- Accepts load/store requests on a valid/ready request channel and performs byte-masked writes at the accept edge.
- Returns exactly one response per accepted request after a programmable latency, and holds it stable under response-channel backpressure.
- Sits on the core-side data bus opposite the execution unit's memory port, and serves as the bench and FPGA data memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, minimum 2.
- LATENCY, 1, cycles from request accept to the first cycle of mem_rsp_valid_o; legal range 1..7.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_addr_i  input  32  byte address; word index = mem_addr_i[log2(DEPTH)+1:2], bits [1:0] and upper bits ignored (aliasing)
- mem_wdata_i  input  32  write data, lane-aligned
- mem_we_i  input  1  1 = store, 0 = load
- mem_sel_i  input  4  byte enables for stores, bit n -> byte lane n; ignored for loads
- mem_req_valid_i  input  1  request valid
- mem_req_ready_o  output  1  request ready
- mem_rsp_valid_o  output  1  response valid
- mem_rsp_ready_i  input  1  response accepted by initiator
- mem_rdata_o  output  32  full aligned word for loads; 32'h0 for store responses

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; mem_rsp_valid_o = 0; mem_rdata_o = 0; latency counter = 0.
  - mem_req_ready_o = 1 once reset deasserts.
  - RAM contents are not reset.
- States:
  - IDLE: no request outstanding.
  - WAIT: request accepted, latency counting. Entered only when LATENCY > 1.
  - RSP: response presented.
- Ready rule: mem_req_ready_o = (state==IDLE) | (state==RSP & mem_rsp_ready_i). It is combinational from mem_rsp_ready_i; it must not depend on mem_req_valid_i.
- Accept: a request is accepted on a rising edge where mem_req_valid_i & mem_req_ready_o.
- At accept:
  - Store: write RAM[idx] byte lanes where mem_sel_i[n]=1; other lanes unchanged. Capture rsp data = 0.
  - Load: capture RAM[idx] as rsp data, using the pre-edge contents.
  - Load counter with LATENCY-1.
  - Next state: RSP if LATENCY==1, else WAIT.
- WAIT: counter decrements by 1 each cycle. When the counter reaches 1, the next state is RSP. Total accept-to-valid latency is exactly LATENCY cycles. mem_req_ready_o = 0.
- RSP: mem_rsp_valid_o = 1 and mem_rdata_o = captured data. Both are held stable until mem_rsp_ready_i = 1.
  - mem_rsp_ready_i=1 and no new request: go to IDLE; mem_rsp_valid_o drops next cycle; mem_rdata_o returns to 0.
  - mem_rsp_ready_i=1 and a new request in the same cycle: the response completes and the new request is accepted at the same edge (back-to-back). The next state follows the accept rule. Sustained throughput is 1 request per cycle with LATENCY=1.
- The initiator may drop mem_req_valid_i while not accepted. The responder takes no action on an unaccepted request.
- Store with mem_sel_i=4'b0000: no RAM change; a response is still returned.
- Outstanding limit: at most one outstanding request. A second request is never accepted before the prior response handshake.
- Reset mid-operation: a pending response is discarded and state returns to IDLE. A store already written at its accept edge remains in RAM.
- mem_rdata_o is registered; there is no combinational path from mem_addr_i to mem_rdata_o.

Test Plan:
- Basic store/load, LATENCY=1: store addr 0x10, data 0xDEADBEEF, sel 4'hF; then load 0x10.
  - Store response arrives 1 cycle after accept with rdata 0.
  - Load response arrives 1 cycle after accept with rdata 0xDEADBEEF.
- Byte-masked store: preload 0x11223344 at addr 0x20; store data 0xAABBCCDD, sel 4'b0101; load 0x20 -> rdata 0x11BB33DD. A store with sel 4'b0000 leaves the word unchanged and still gets one response.
- Backpressure: hold mem_rsp_ready_i=0 for 5 cycles after a load of 0xCAFEF00D.
  - rsp_valid stays 1 and rdata stays 0xCAFEF00D throughout.
  - mem_req_ready_o stays 0; a concurrent valid request is not accepted.
- Back-to-back, LATENCY=1, rsp_ready tied 1: 8 consecutive loads of distinct addresses.
  - One accept per cycle.
  - Responses return in order, each 1 cycle after its accept.
- LATENCY=4: a load accepted at cycle N -> rsp_valid first high at N+4; mem_req_ready_o low for cycles N+1..N+3.
- Reset mid-operation: assert rst_n=0 while in WAIT after a store of 0x55AA55AA to 0x40.
  - rsp_valid=0 and rdata=0 immediately (asynchronous).
  - After release, a load of 0x40 returns 0x55AA55AA.
  - Address aliasing: with DEPTH=1024, a load of 0x1040 also returns 0x55AA55AA.
